mm2st: RTL and testbench

- Reverse-direction companion of st2mm. Reads a contiguous block of words from an Avalon-MM slave (sensor/histogram RAM) and emits it as one Avalon-ST packet.
- Sits between the on-chip buffer RAM and the downstream streaming path (packetiser/Ethernet framer).
- Software/control logic pulses start with a base address and word count. The block drives reads and delivers data under ST backpressure through a small internal FIFO.

---
 rtl/mm2st_pkg.sv | 6 +
 rtl/sc_fifo.sv | 35 +++
 rtl/mm2st.sv | 96 +++++++++
 tb/tb_mm2st.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mm2st_pkg.sv
// mm2st_pkg: shared state encoding and constants for the mm2st/st2mm pair
package mm2st_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int MM_READ_LATENCY = 1;
endpackage

// File: rtl/sc_fifo.sv
// sc_fifo: single-clock show-ahead FIFO with occupancy count
module sc_fifo #(
  parameter int BITSIZE = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [BITSIZE-1:0] wr_data,
  input  logic               rd_en,
  output logic [BITSIZE-1:0] rd_data,
  output logic [CW-1:0]      count,
  output logic               empty
);
  logic [BITSIZE-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign empty = count == '0;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
endmodule

// File: rtl/mm2st.sv
// mm2st: reads a contiguous Avalon-MM word block and emits it as one Avalon-ST packet
module mm2st import mm2st_pkg::*; #(
  parameter int BITSIZE = 32,
  parameter int EMPTY_SIZE = 2,
  parameter int ADDR_WIDTH = 9,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [EMPTY_SIZE-1:0] last_empty,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mm_address,
  output logic                  mm_chipselect,
  output logic                  mm_read,
  input  logic [BITSIZE-1:0]    mm_readdata,
  input  logic                  mm_waitrequest_n,
  output logic [BITSIZE-1:0]    data_out_data,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [EMPTY_SIZE-1:0] data_out_empty,
  output logic                  data_out_startofpacket,
  output logic                  data_out_endofpacket
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  state_t state;
  logic [ADDR_WIDTH:0] reads_rem, beats, len_r;
  logic [EMPTY_SIZE-1:0] empty_r;
  logic [CW-1:0] fifo_count;
  logic inflight, fifo_empty, accept, pop;
  // credit: words buffered plus the read in flight must leave room in the FIFO
  assign mm_read = state == READ && reads_rem != '0 && int'(fifo_count) + int'(inflight) < FIFO_DEPTH;
  assign mm_chipselect = mm_read;
  assign accept = mm_read && mm_waitrequest_n;
  assign data_out_valid = !fifo_empty;
  assign pop = data_out_valid && data_out_ready;
  assign data_out_startofpacket = data_out_valid && beats == '0;
  assign data_out_endofpacket = data_out_valid && beats == len_r - ONE;
  assign data_out_empty = data_out_endofpacket ? empty_r : '0;
  sc_fifo #(.BITSIZE(BITSIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(inflight),
    .wr_data(mm_readdata),
    .rd_en(pop),
    .rd_data(data_out_data),
    .count(fifo_count),
    .empty(fifo_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mm_address <= '0;
      reads_rem <= '0;
      beats <= '0;
      len_r <= '0;
      empty_r <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        mm_address <= mm_address + ADDR_WIDTH'(1);
        reads_rem <= reads_rem - ONE;
      end
      if (pop) beats <= beats + ONE;
      case (state)
        IDLE: if (start) begin
          mm_address <= start_addr;
          reads_rem <= length;
          len_r <= length;
          empty_r <= last_empty;
          beats <= '0;
          busy <= length != '0;
          done <= length == '0;
          state <= length == '0 ? FIN : READ;
        end
        READ: if (accept && reads_rem == ONE) state <= DRAIN;
        DRAIN: if (pop && data_out_endofpacket) begin
          state <= FIN;
          busy <= 1'b0;
          done <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mm2st.sv
// tb_mm2st: scoreboard bench for mm2st with an Avalon-MM slave model and ST sink
module tb_mm2st;
  logic clk = 0, rst_n = 0, start = 0;
  logic [8:0] start_addr = '0;
  logic [9:0] length = '0;
  logic [1:0] last_empty = '0;
  logic busy, done, mm_chipselect, mm_read;
  logic [8:0] mm_address;
  logic [31:0] mm_readdata = '0;
  logic mm_waitrequest_n = 1;
  logic [31:0] data_out_data;
  logic data_out_valid, data_out_ready = 1, sop, eop;
  logic [1:0] data_out_empty;
  typedef struct packed {logic [31:0] d; logic s; logic e; logic [1:0] m;} beat_t;
  beat_t exp_beat[$];
  logic [8:0] exp_addr[$];
  int errors = 0, checks = 0, done_cnt = 0, beats_seen = 0, outstanding = 0;
  logic rmode = 0, stall_req = 0;

  always #5 clk = ~clk;

  mm2st dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
    .last_empty(last_empty), .busy(busy), .done(done), .mm_address(mm_address),
    .mm_chipselect(mm_chipselect), .mm_read(mm_read), .mm_readdata(mm_readdata),
    .mm_waitrequest_n(mm_waitrequest_n), .data_out_data(data_out_data),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .data_out_empty(data_out_empty), .data_out_startofpacket(sop), .data_out_endofpacket(eop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // slave model: latency-1 RAM with RAM[a]=a, optional waitrequest stall, ready pattern 1,0,0,1
  initial begin : slave
    logic acc;
    logic [8:0] a;
    int stall_cnt, rc;
    bit used;
    stall_cnt = 0; rc = 0; used = 0;
    forever begin
      @(negedge clk);
      acc = mm_read && mm_waitrequest_n && rst_n;
      a = mm_address;
      if (acc) begin
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_addr: got read at %h expected none", a);
        end else chk("read_addr", a, exp_addr.pop_front());
      end
      @(posedge clk); #1;
      if (acc) mm_readdata = {23'd0, a};
      if (stall_req && !used && acc) begin used = 1; stall_cnt = 5; end
      if (!stall_req) used = 0;
      mm_waitrequest_n = stall_cnt == 0;
      if (stall_cnt != 0) stall_cnt--;
      data_out_ready = !rmode || rc % 4 == 0 || rc % 4 == 3;
      rc = rmode ? rc + 1 : 0;
    end
  end

  initial begin : monitor
    beat_t cur, prev;
    bit stall, wprev;
    logic [8:0] paddr;
    stall = 0; wprev = 0; prev = '0; paddr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0; wprev = 0; outstanding = 0;
      end else begin
        cur = {data_out_data, sop, eop, data_out_empty};
        if (stall) chk("stall_hold", {cur, data_out_valid}, {prev, 1'b1});
        if (wprev) chk("wait_hold", {mm_read, mm_address}, {1'b1, paddr});
        if (mm_read) begin
          chk("credit", outstanding < 4, 1);
          chk("chipselect", mm_chipselect, 1);
        end
        if (data_out_valid && data_out_ready) begin
          beats_seen++;
          if (exp_beat.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat: got %h expected none", cur);
          end else chk("beat", cur, exp_beat.pop_front());
        end
        outstanding += int'(mm_read && mm_waitrequest_n) - int'(data_out_valid && data_out_ready);
        stall = data_out_valid && !data_out_ready;
        prev = cur;
        wprev = mm_read && !mm_waitrequest_n;
        paddr = mm_address;
        if (done) done_cnt++;
      end
    end
  end

  task automatic push_pkt(input logic [8:0] a, input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) begin
      logic [8:0] ai;
      ai = a + 9'(i);
      exp_addr.push_back(ai);
      exp_beat.push_back({23'd0, ai, i == 0, i == n - 1, i == n - 1 ? m : 2'd0});
    end
  endtask

  task automatic pulse_start(input logic [8:0] a, input int n, input logic [1:0] m);
    @(posedge clk); #1;
    start = 1; start_addr = a; length = 10'(n); last_empty = m;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
  endtask

  task automatic run_pkt(input logic [8:0] a, input int n, input logic [1:0] m, input bit extra);
    int d0;
    d0 = done_cnt;
    push_pkt(a, n, m);
    pulse_start(a, n, m);
    chk("busy_after_start", busy, n != 0);
    chk("first_read", mm_read, n != 0);
    if (extra) begin
      repeat (2) @(negedge clk);
      chk("busy_before_extra", busy, 1);
      pulse_start(9'h100, 5, 2'd1);
    end
    for (int k = 0; k < 500 && !done; k++) @(negedge clk);
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("beats_left", exp_beat.size(), 0);
    chk("reads_left", exp_addr.size(), 0);
    rmode = 0;
    stall_req = 0;
  endtask

  initial begin
    int d0, b0;
    #1;
    chk("reset_state", {busy, done, mm_read, mm_chipselect, mm_address, data_out_valid, sop, eop, data_out_empty, data_out_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_pkt(9'h010, 4, 2'd2, 0);
    rmode = 1;
    run_pkt(9'h020, 8, 2'd1, 0);
    stall_req = 1;
    run_pkt(9'h040, 3, 2'd3, 0);
    run_pkt(9'h1FF, 2, 2'd1, 0);
    run_pkt(9'h055, 1, 2'd3, 0);
    run_pkt(9'h000, 0, 2'd0, 0);
    run_pkt(9'h080, 5, 2'd0, 1);
    d0 = done_cnt;
    b0 = beats_seen;
    push_pkt(9'h0A0, 6, 2'd2);
    pulse_start(9'h0A0, 6, 2'd2);
    for (int k = 0; k < 200 && beats_seen < b0 + 2; k++) @(posedge clk);
    chk("beats_before_reset", beats_seen - b0, 2);
    #2 rst_n = 0;
    #1;
    chk("rst_outputs", {busy, done, mm_read, mm_chipselect, mm_address, data_out_valid, sop, eop, data_out_empty, data_out_data}, 0);
    exp_beat.delete();
    exp_addr.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("idle_after_reset", {busy, mm_read, data_out_valid}, 0);
    run_pkt(9'h0C0, 6, 2'd2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
